// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared encodings for the decode-stage branch hazard logic:
//               comparator forward selects, Tnew/Tuse constants and the
//               pipeline slot record.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

   // Comparator operand source selects
   localparam logic [1:0] FWD_GRF = 2'b00;
   localparam logic [1:0] FWD_E   = 2'b01;
   localparam logic [1:0] FWD_M   = 2'b10;
   localparam logic [1:0] FWD_W   = 2'b11;

   // Result latency after entering E, and operand deadline of the branch
   localparam int TNEW_PC8    = 0;
   localparam int TNEW_ALU    = 1;
   localparam int TNEW_LOAD   = 2;
   localparam int TUSE_BRANCH = 0;

   // Default-width slot record {destination register, remaining latency}
   localparam int SLOT_REG_W = 5;
   localparam int SLOT_T_W   = 2;

   typedef struct packed {
      logic [SLOT_REG_W-1:0] wr_addr;
      logic [SLOT_T_W-1:0]   tnew;
   } slot_t;

endpackage
`default_nettype wire

// File: rtl/hz_operand_check.sv
`default_nettype none
// ============================================================================
// Module      : hz_operand_check
// Description : Per-operand hazard check. Finds the youngest in-flight slot
//               writing the source register and decides stall / forward.
// Revision    : 1.0 - initial release
// ============================================================================
module hz_operand_check
   import hazard_pkg::*;
#(
   parameter int REG_W = 5,
   parameter int T_W   = 2
) (
   input  logic [REG_W-1:0] src_addr_i,
   input  logic             src_read_i,
   input  logic [T_W-1:0]   tuse_i,
   input  logic [REG_W-1:0] e_addr_i,
   input  logic [T_W-1:0]   e_tnew_i,
   input  logic [REG_W-1:0] m_addr_i,
   input  logic [T_W-1:0]   m_tnew_i,
   input  logic [REG_W-1:0] w_addr_i,
   input  logic [T_W-1:0]   w_tnew_i,
   output logic             stall_req_o,
   output logic [1:0]       fwd_sel_o
);

   logic           w_hit;
   logic [T_W-1:0] w_win_tnew;
   logic [1:0]     w_win_sel;

   // Youngest matching slot wins; register 0 and unread operands never match
   always_comb begin
      w_hit      = 1'b0;
      w_win_tnew = '0;
      w_win_sel  = FWD_GRF;
      if (src_read_i && (src_addr_i != '0)) begin
         if (e_addr_i == src_addr_i) begin
            w_hit      = 1'b1;
            w_win_tnew = e_tnew_i;
            w_win_sel  = FWD_E;
         end else if (m_addr_i == src_addr_i) begin
            w_hit      = 1'b1;
            w_win_tnew = m_tnew_i;
            w_win_sel  = FWD_M;
         end else if (w_addr_i == src_addr_i) begin
            w_hit      = 1'b1;
            w_win_tnew = w_tnew_i;
            w_win_sel  = FWD_W;
         end
      end
   end

   // Stall while the producer is later than the deadline; forward once ready
   assign stall_req_o = w_hit && (w_win_tnew > tuse_i);
   assign fwd_sel_o   = (w_hit && (w_win_tnew == '0)) ? w_win_sel : FWD_GRF;

endmodule
`default_nettype wire

// File: rtl/d_branch_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : d_branch_hazard_ctrl
// Description : Scoreboard hazard/forwarding controller for the decode-stage
//               branch comparator. Tracks {wr_addr, tnew} of E/M/W, drives
//               the D stall and comparator forward selects, counts stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module d_branch_hazard_ctrl #(
   parameter int REG_W = 5,
   parameter int T_W   = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             d_valid,
   input  logic [REG_W-1:0] d_rs_addr,
   input  logic [REG_W-1:0] d_rt_addr,
   input  logic             d_rs_read,
   input  logic             d_rt_read,
   input  logic [T_W-1:0]   d_tuse_rs,
   input  logic [T_W-1:0]   d_tuse_rt,
   input  logic [REG_W-1:0] d_wr_addr,
   input  logic [T_W-1:0]   d_tnew,
   output logic             stall,
   output logic [1:0]       fwd_sel_rs,
   output logic [1:0]       fwd_sel_rt,
   output logic [CNT_W-1:0] stall_cnt
);

   logic [REG_W-1:0] e_addr_q, m_addr_q, w_addr_q;
   logic [T_W-1:0]   e_tnew_q, m_tnew_q, w_tnew_q;
   logic [REG_W-1:0] e_addr_d, m_addr_d, w_addr_d;
   logic [T_W-1:0]   e_tnew_d, m_tnew_d, w_tnew_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             w_stall_rs, w_stall_rt;

   // One cycle of ageing: latency counts down and holds at zero
   function automatic logic [T_W-1:0] age(input logic [T_W-1:0] t);
      return (t == '0) ? '0 : t - T_W'(1);
   endfunction

   hz_operand_check #(.REG_W(REG_W), .T_W(T_W)) u_chk_rs (
      .src_addr_i  (d_rs_addr),
      .src_read_i  (d_rs_read),
      .tuse_i      (d_tuse_rs),
      .e_addr_i    (e_addr_q),
      .e_tnew_i    (e_tnew_q),
      .m_addr_i    (m_addr_q),
      .m_tnew_i    (m_tnew_q),
      .w_addr_i    (w_addr_q),
      .w_tnew_i    (w_tnew_q),
      .stall_req_o (w_stall_rs),
      .fwd_sel_o   (fwd_sel_rs)
   );

   hz_operand_check #(.REG_W(REG_W), .T_W(T_W)) u_chk_rt (
      .src_addr_i  (d_rt_addr),
      .src_read_i  (d_rt_read),
      .tuse_i      (d_tuse_rt),
      .e_addr_i    (e_addr_q),
      .e_tnew_i    (e_tnew_q),
      .m_addr_i    (m_addr_q),
      .m_tnew_i    (m_tnew_q),
      .w_addr_i    (w_addr_q),
      .w_tnew_i    (w_tnew_q),
      .stall_req_o (w_stall_rt),
      .fwd_sel_o   (fwd_sel_rt)
   );

   assign stall     = d_valid && (w_stall_rs || w_stall_rt);
   assign stall_cnt = cnt_q;

   // Next slot contents: D enters E unless stalled/invalid, older slots age
   always_comb begin
      e_addr_d = '0;
      e_tnew_d = '0;
      if (d_valid && !stall) begin
         e_addr_d = d_wr_addr;
         e_tnew_d = d_tnew;
      end
      m_addr_d = e_addr_q;
      m_tnew_d = age(e_tnew_q);
      w_addr_d = m_addr_q;
      w_tnew_d = age(m_tnew_q);
      cnt_d    = cnt_q;
      if (stall && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Slot and counter registers; reset empties the pipeline view immediately
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         e_addr_q <= '0;
         e_tnew_q <= '0;
         m_addr_q <= '0;
         m_tnew_q <= '0;
         w_addr_q <= '0;
         w_tnew_q <= '0;
         cnt_q    <= '0;
      end else begin
         e_addr_q <= e_addr_d;
         e_tnew_q <= e_tnew_d;
         m_addr_q <= m_addr_d;
         m_tnew_q <= m_tnew_d;
         w_addr_q <= w_addr_d;
         w_tnew_q <= w_tnew_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_d_branch_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_d_branch_hazard_ctrl
// Description : Self-checking bench for d_branch_hazard_ctrl. A history of
//               the last three issued instructions stands in for E/M/W; an
//               instruction k cycles past E has latency max(tnew-k, 0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_d_branch_hazard_ctrl;

   logic        clk;
   logic        reset;
   logic        d_valid;
   logic [4:0]  d_rs_addr, d_rt_addr, d_wr_addr;
   logic        d_rs_read, d_rt_read;
   logic [1:0]  d_tuse_rs, d_tuse_rt, d_tnew;
   logic        stall;
   logic [1:0]  fwd_sel_rs, fwd_sel_rt;
   logic [15:0] stall_cnt;

   int total = 0;
   int bad   = 0;

   // Model: hist 0 = newest issued (E), 1 = M, 2 = W
   int h_addr [3];
   int h_tnew [3];
   int m_cnt;

   d_branch_hazard_ctrl #(.REG_W(5), .T_W(2), .CNT_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .d_valid    (d_valid),
      .d_rs_addr  (d_rs_addr),
      .d_rt_addr  (d_rt_addr),
      .d_rs_read  (d_rs_read),
      .d_rt_read  (d_rt_read),
      .d_tuse_rs  (d_tuse_rs),
      .d_tuse_rt  (d_tuse_rt),
      .d_wr_addr  (d_wr_addr),
      .d_tnew     (d_tnew),
      .stall      (stall),
      .fwd_sel_rs (fwd_sel_rs),
      .fwd_sel_rt (fwd_sel_rt),
      .stall_cnt  (stall_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void op_model(input int src, input bit rd, input int tuse,
                                    output bit st, output int fwd);
      bit found = 0;
      st  = 0;
      fwd = 0;
      for (int k = 0; k < 3; k++) begin
         if (!found && rd && src != 0 && h_addr[k] == src) begin
            int eff;
            found = 1;
            eff = h_tnew[k] - k;
            if (eff < 0) eff = 0;
            st  = (eff > tuse);
            fwd = (eff == 0) ? k + 1 : 0;
         end
      end
   endfunction

   function automatic void model_eval(output bit st, output int frs, output int frt);
      bit srs, srt;
      op_model(int'(d_rs_addr), d_rs_read, int'(d_tuse_rs), srs, frs);
      op_model(int'(d_rt_addr), d_rt_read, int'(d_tuse_rt), srt, frt);
      st = d_valid && (srs || srt);
   endfunction

   // Model advance on every edge, cleared by reset
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < 3; k++) begin
            h_addr[k] <= 0;
            h_tnew[k] <= 0;
         end
         m_cnt <= 0;
      end else begin
         bit st;
         int a, b;
         model_eval(st, a, b);
         h_addr[2] <= h_addr[1];
         h_tnew[2] <= h_tnew[1];
         h_addr[1] <= h_addr[0];
         h_tnew[1] <= h_tnew[0];
         h_addr[0] <= (d_valid && !st) ? int'(d_wr_addr) : 0;
         h_tnew[0] <= (d_valid && !st) ? int'(d_tnew) : 0;
         if (st && m_cnt < 65535) m_cnt <= m_cnt + 1;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_model();
      bit st;
      int frs, frt;
      model_eval(st, frs, frt);
      chk("model_stall", int'(stall), int'(st));
      chk("model_fwd_rs", int'(fwd_sel_rs), frs);
      chk("model_fwd_rt", int'(fwd_sel_rt), frt);
      chk("model_cnt", int'(stall_cnt), m_cnt);
   endtask

   task automatic drive(input bit v, input int rs, input int rt, input bit rsr, input bit rtr,
                        input int tu_rs, input int tu_rt, input int wr, input int tn);
      d_valid   = v;
      d_rs_addr = 5'(rs);
      d_rt_addr = 5'(rt);
      d_rs_read = rsr;
      d_rt_read = rtr;
      d_tuse_rs = 2'(tu_rs);
      d_tuse_rt = 2'(tu_rt);
      d_wr_addr = 5'(wr);
      d_tnew    = 2'(tn);
   endtask

   // Compare against the model mid-cycle, then advance one edge
   task automatic step();
      @(negedge clk);
      cmp_model();
      @(posedge clk);
      #1;
   endtask

   task automatic beq(input int rs, input int rt);
      drive(1, rs, rt, 1, 1, 0, 0, 0, 0);
   endtask

   initial begin
      bit mst;
      int ma, mb;
      reset = 1'b1;
      beq(1, 2);
      #1 reset = 1'b0;
      #1;
      chk("rst_stall", int'(stall), 0);
      chk("rst_fwd_rs", int'(fwd_sel_rs), 0);
      chk("rst_fwd_rt", int'(fwd_sel_rt), 0);
      chk("rst_cnt", int'(stall_cnt), 0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // addu $3 (ALU) then beq $3,$0: one stall, then M forward
      drive(1, 0, 0, 0, 0, 1, 1, 3, 1);
      step();
      beq(3, 0);
      #1 chk("alu_stall", int'(stall), 1);
      step();
      chk("alu_release", int'(stall), 0);
      chk("alu_fwd_rs", int'(fwd_sel_rs), 2);
      chk("alu_cnt", int'(stall_cnt), 1);
      step();

      // lw $4 then beq $4,$4: two stalls, load reaches W with latency 0
      drive(1, 0, 0, 0, 0, 1, 1, 4, 2);
      step();
      beq(4, 4);
      #1 chk("lw_stall1", int'(stall), 1);
      step();
      chk("lw_stall2", int'(stall), 1);
      step();
      chk("lw_release", int'(stall), 0);
      chk("lw_fwd_rs", int'(fwd_sel_rs), 3);
      chk("lw_fwd_rt", int'(fwd_sel_rt), 3);
      chk("lw_cnt", int'(stall_cnt), 3);
      step();

      // jal (wr 31, tnew 0) then beq $31,$0: forward from E, no stall
      drive(1, 0, 0, 0, 0, 1, 1, 31, 0);
      step();
      beq(31, 0);
      #1 chk("jal_stall", int'(stall), 0);
      chk("jal_fwd_rs", int'(fwd_sel_rs), 1);
      step();

      // Writes to register 0 are never tracked
      drive(1, 0, 0, 0, 0, 1, 1, 0, 1);
      step();
      beq(0, 0);
      #1 chk("r0_stall", int'(stall), 0);
      chk("r0_fwd_rs", int'(fwd_sel_rs), 0);
      chk("r0_fwd_rt", int'(fwd_sel_rt), 0);
      step();

      // Random traffic; D is held while the model says stall
      for (int i = 0; i < 1500; i++) begin
         model_eval(mst, ma, mb);
         if (!mst) begin
            drive(($urandom_range(0, 9) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                  $urandom_range(0, 3), $urandom_range(0, 2));
         end
         step();
      end

      // Reset asserted during a load-use stall
      drive(1, 0, 0, 0, 0, 1, 1, 5, 2);
      step();
      beq(5, 0);
      #1 chk("mid_stall", int'(stall), 1);
      reset = 1'b0;
      #1;
      chk("mid_rst_stall", int'(stall), 0);
      chk("mid_rst_fwd_rs", int'(fwd_sel_rs), 0);
      chk("mid_rst_cnt", int'(stall_cnt), 0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_stall", int'(stall), 0);
      chk("post_rst_cnt", int'(stall_cnt), 0);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
